// File: rtl/tbb1143_bus_writer.sv
// Serialises nibble/byte write commands onto TBB1143 A0/D/WR; first WR rise SETUP_CYC+1 edges after accept.
// cmd_ready drops when storage is full (TBB_WRITER_FIFO_EN: 4-entry FIFO, otherwise one holding register).
module tbb1143_bus_writer #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  input  logic       cmd_wide,
  output logic [3:0] BUS_D,
  output logic       BUS_A0,
  output logic       BUS_WR,
  output logic       busy
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic       pop, load_lo, load_hi;
  logic       push;
  logic       q_vld, q_a0, q_wide;
  logic [7:0] q_data;
  logic       ready_d, stored_d;
  logic [3:0] hi_q;
  logic       wide_q, second_q;

  assign push = cmd_valid & cmd_ready;

`ifdef TBB_WRITER_FIFO_EN
  logic [9:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] occ, occ_d;

  assign occ_d                     = occ + {2'b00, push} - {2'b00, pop};
  assign q_vld                     = (occ != 3'd0);
  assign {q_a0, q_wide, q_data}    = mem[rd_ptr];
  assign ready_d                   = (occ_d != 3'd4);
  assign stored_d                  = (occ_d != 3'd0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      occ <= occ_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {cmd_a0, cmd_wide, cmd_data};
  end
`else
  logic       hold_vld, hold_vld_d;
  logic [9:0] hold_q;

  // push and pop are mutually exclusive here: ready implies the register is empty
  always_comb begin
    hold_vld_d = hold_vld;
    if (pop)  hold_vld_d = 1'b0;
    if (push) hold_vld_d = 1'b1;
  end

  assign q_vld                  = hold_vld;
  assign {q_a0, q_wide, q_data} = hold_q;
  assign ready_d                = ~hold_vld_d;
  assign stored_d               = hold_vld_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_vld <= 1'b0;
      hold_q   <= 10'd0;
    end else begin
      hold_vld <= hold_vld_d;
      if (push) hold_q <= {cmd_a0, cmd_wide, cmd_data};
    end
  end
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pop     = 1'b0;
    load_lo = 1'b0;
    load_hi = 1'b0;
    case (state)
      IDLE: begin
        if (q_vld) begin
          pop     = 1'b1;
          load_lo = 1'b1;
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else if (wide_q && !second_q) begin
          load_hi = 1'b1;
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end else if (q_vld) begin
          // chain straight into the next command without an IDLE bubble
          pop     = 1'b1;
          load_lo = 1'b1;
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      BUS_WR    <= 1'b0;
      BUS_D     <= 4'd0;
      BUS_A0    <= 1'b0;
      hi_q      <= 4'd0;
      wide_q    <= 1'b0;
      second_q  <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      BUS_WR    <= (state_d == STROBE);
      busy      <= (state_d != IDLE) || stored_d;
      cmd_ready <= ready_d;
      if (load_lo) begin
        BUS_A0   <= q_a0;
        BUS_D    <= q_data[3:0];
        hi_q     <= q_data[7:4];
        wide_q   <= q_wide;
        second_q <= 1'b0;
      end
      if (load_hi) begin
        BUS_D    <= hi_q;
        second_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tbb1143_bus_writer.sv
// Scoreboarded bench for tbb1143_bus_writer: default-timing instance plus a SETUP=3/STROBE=1/HOLD=15 instance.
module tb_tbb1143_bus_writer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cmd_valid = 1'b0, cmd_a0 = 1'b0, cmd_wide = 1'b0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_ready, BUS_A0, BUS_WR, busy;
  logic [3:0] BUS_D;

  logic       c1_valid = 1'b0, c1_a0 = 1'b0, c1_wide = 1'b0;
  logic [7:0] c1_data = 8'd0;
  logic       c1_ready, b1_a0, b1_wr, b1_busy;
  logic [3:0] b1_d;

  always #5 CLK = ~CLK;

  tbb1143_bus_writer u0 (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a0(cmd_a0), .cmd_data(cmd_data), .cmd_wide(cmd_wide),
    .BUS_D(BUS_D), .BUS_A0(BUS_A0), .BUS_WR(BUS_WR), .busy(busy)
  );

  tbb1143_bus_writer #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(15)) u1 (
    .CLK(CLK), .RST(RST), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_a0(c1_a0), .cmd_data(c1_data), .cmd_wide(c1_wide),
    .BUS_D(b1_d), .BUS_A0(b1_a0), .BUS_WR(b1_wr), .busy(b1_busy)
  );

  typedef struct packed {
    logic       a0;
    logic [3:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   rise_cyc[$];
  int   rises = 0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   prev_wr = 1'b0;
  bit   in_pulse = 1'b0;
  int   width = 0;
  exp_t cur;

  task automatic chk(input string name, input int got, input int want);
    total_cnt++;
    if (got == want) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // Monitor: every WR rise consumes one expected nibble; width and hold are checked on the fall.
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      in_pulse = 1'b0;
      prev_wr  = 1'b0;
    end else begin
      if (BUS_WR && !prev_wr) begin
        rises++;
        rise_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_wr_pulse", 1, 0);
          in_pulse = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          chk("bus_d", int'(BUS_D), int'(cur.d));
          chk("bus_a0", int'(BUS_A0), int'(cur.a0));
          in_pulse = 1'b1;
          width    = 1;
        end
      end else if (BUS_WR && prev_wr) begin
        width++;
      end else if (!BUS_WR && prev_wr && in_pulse) begin
        chk("strobe_width", width, 2);
        chk("hold_d", int'(BUS_D), int'(cur.d));
        in_pulse = 1'b0;
      end
      prev_wr = BUS_WR;
    end
  end

  task automatic send(input logic a0, input logic [7:0] data, input logic wide);
    bit   done = 1'b0;
    exp_t e;
    @(negedge CLK);
    cmd_valid = 1'b1;
    cmd_a0    = a0;
    cmd_data  = data;
    cmd_wide  = wide;
    for (int i = 0; i < 40 && !done; i++) begin
      if (cmd_ready) begin
        @(posedge CLK);
        done   = 1'b1;
        e.a0   = a0;
        e.d    = data[3:0];
        exp_q.push_back(e);
        if (wide) begin
          e.d = data[7:4];
          exp_q.push_back(e);
        end
        #1 cmd_valid = 1'b0;
      end else begin
        @(negedge CLK);
      end
    end
    if (!done) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(output int n);
    bit idle = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge CLK);
      n++;
      if (!busy) idle = 1'b1;
    end
    if (!idle) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int        n, r0, k;
    bit        hit, stable;
    logic [5:0] wr_pat, busy_pat;

    #12;
    chk("rst_bus_d", int'(BUS_D), 0);
    chk("rst_bus_a0", int'(BUS_A0), 0);
    chk("rst_bus_wr", int'(BUS_WR), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_u1_ready", int'(c1_ready), 1);
    @(negedge CLK);
    #2 RST = 1'b0;
    repeat (2) @(negedge CLK);

    // single narrow write: per-cycle WR/busy profile after the accept edge
    wr_pat   = 6'b001100;
    busy_pat = 6'b111110;
    send(1'b1, 8'h0A, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk($sformatf("narrow_wr_c%0d", i), int'(BUS_WR), int'(wr_pat[5-i]));
      chk($sformatf("narrow_busy_c%0d", i), int'(busy), int'(busy_pat[5-i]));
      if (i == 0) begin
`ifdef TBB_WRITER_FIFO_EN
        chk("narrow_ready_after_accept", int'(cmd_ready), 1);
`else
        chk("narrow_ready_after_accept", int'(cmd_ready), 0);
`endif
      end
      if (i == 1) begin
        chk("narrow_d_after_pop", int'(BUS_D), 10);
        chk("narrow_a0_after_pop", int'(BUS_A0), 1);
        chk("narrow_ready_after_pop", int'(cmd_ready), 1);
      end
    end

    // wide write 0x5C: two pulses (C then 5), idle 10 negedges after accept
    r0 = rises;
    send(1'b0, 8'h5C, 1'b1);
    wait_idle(n);
    chk("wide_idle_cycles", n, 10);
    chk("wide_pulse_count", rises - r0, 2);
    chk("wide_a0_hold", int'(BUS_A0), 0);

    // back-to-back narrow commands: pulses exactly 4 cycles apart
    r0 = rise_cyc.size();
    send(1'b0, 8'h01, 1'b0);
    send(1'b0, 8'h02, 1'b0);
    send(1'b0, 8'h03, 1'b0);
    wait_idle(n);
    chk("b2b_pulse_count", rise_cyc.size() - r0, 3);
    if (rise_cyc.size() - r0 == 3) begin
      chk("b2b_spacing_1", rise_cyc[r0+1] - rise_cyc[r0], 4);
      chk("b2b_spacing_2", rise_cyc[r0+2] - rise_cyc[r0+1], 4);
    end

`ifdef TBB_WRITER_FIFO_EN
    // fill the FIFO behind an in-flight command; order must survive pointer wrap
    r0 = rises;
    send(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(i[0], 8'(i + 2), 1'b0);
      if (i == 2) chk("fifo_ready_at_3", int'(cmd_ready), 1);
      if (i == 3) chk("fifo_ready_at_4", int'(cmd_ready), 0);
    end
    wait_idle(n);
    chk("fifo_pulse_count", rises - r0, 7);
`endif

    // reset while WR is high in the middle of a wide command
    send(1'b1, 8'h96, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge CLK);
      if (BUS_WR) hit = 1'b1;
    end
    chk("rstmid_saw_wr", int'(hit), 1);
    #2 RST = 1'b1;
    #1;
    chk("rstmid_wr", int'(BUS_WR), 0);
    chk("rstmid_d", int'(BUS_D), 0);
    chk("rstmid_a0", int'(BUS_A0), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_ready", int'(cmd_ready), 1);
    exp_q.delete();
    r0 = rises;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    repeat (30) @(negedge CLK);
    chk("rstmid_no_resend", rises - r0, 0);
    send(1'b0, 8'h03, 1'b0);
    wait_idle(n);
    chk("rstmid_new_cmd", rises - r0, 1);

    // slow-timing instance: SETUP=3, STROBE=1, HOLD=15
    @(negedge CLK);
    c1_valid = 1'b1;
    c1_a0    = 1'b1;
    c1_data  = 8'h07;
    c1_wide  = 1'b0;
    chk("u1_ready_idle", int'(c1_ready), 1);
    @(posedge CLK);
    #1 c1_valid = 1'b0;
    n   = 0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge CLK);
      n++;
      if (b1_wr) hit = 1'b1;
    end
    chk("u1_wr_rise_cycle", n, 5);
    chk("u1_d", int'(b1_d), 7);
    chk("u1_a0", int'(b1_a0), 1);
    @(negedge CLK);
    chk("u1_strobe_1cyc", int'(b1_wr), 0);
    k      = 0;
    stable = 1'b1;
    hit    = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge CLK);
      k++;
      if (b1_d != 4'h7 || b1_wr) stable = 1'b0;
      if (!b1_busy) hit = 1'b1;
    end
    chk("u1_hold_cycles", k, 15);
    chk("u1_hold_stable", int'(stable), 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule

// File: doc/tbb1143_bus_writer.md
# tbb1143_bus_writer

Host-side bus initiator for the TBB1143 nibble write port. It accepts write commands over a valid/ready handshake and serialises them onto the chip's `A0`, `D[3:0]` and `WR` pins with programmable setup, strobe and hold timing. It sits in the test/harness FPGA or companion logic that drives the TBB1143 input pins. A command carries either one nibble or a full byte, and a byte is sent low nibble first.

## Interface

Parameters:
- `SETUP_CYC`, default 1: cycles `A0`/`D` are stable before `WR` rises. Range 1..15.
- `STROBE_CYC`, default 2: cycles `WR` is high. Range 1..15.
- `HOLD_CYC`, default 1: cycles `A0`/`D` are held after `WR` falls. Range 1..15.

Ports:
- `CLK` input 1: the single clock.
- `RST` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command this cycle.
- `cmd_a0` input 1: value driven on `BUS_A0` for this command.
- `cmd_data` input 8: payload. Bits [3:0] are the first nibble and bits [7:4] are the second.
- `cmd_wide` input 1: 1 sends two nibbles; 0 sends `cmd_data[3:0]` only.
- `BUS_D` output 4: to TBB1143 `D3..D0`.
- `BUS_A0` output 1: to TBB1143 `A0`.
- `BUS_WR` output 1: to TBB1143 `WR`, active high.
- `busy` output 1: the FSM is not IDLE, or a command is queued.

## Operation

- A command is accepted on a rising `CLK` edge when `cmd_valid & cmd_ready`.
- FSM states:
  - IDLE
  - SETUP (`SETUP_CYC` cycles, `WR`=0)
  - STROBE (`STROBE_CYC` cycles, `WR`=1)
  - HOLD (`HOLD_CYC` cycles, `WR`=0)
- The per-state down-counter is 4 bits wide, loaded with N-1 on state entry.
- Launching a command: in IDLE with a command stored, the next edge pops it, registers `BUS_A0`=`cmd_a0` and `BUS_D`=`data[3:0]`, and enters SETUP.
- HOLD exit:
  - If the command is wide and the first nibble has just finished, load `BUS_D`=`data[7:4]` and re-enter SETUP. `A0` is unchanged.
  - Otherwise, if another command is stored, pop it on the same edge and enter SETUP. There is no IDLE bubble.
  - Otherwise, go to IDLE.
- `BUS_D` and `BUS_A0` keep their last values in IDLE. They only change on SETUP entry, so they never change while `WR`=1 or during HOLD.
- Cycles per nibble = `SETUP_CYC+STROBE_CYC+HOLD_CYC`. A wide command takes twice that.
- All outputs are registered; there is no combinational path from `cmd_*` to `BUS_*`.
- Reset value of every output: `BUS_D`=0, `BUS_A0`=0, `BUS_WR`=0, `busy`=0, `cmd_ready`=1. Storage is emptied and the FSM goes to IDLE.
- Reset mid-operation: `BUS_WR` falls asynchronously. Queued and in-flight commands are discarded, and no nibble is re-sent after release.

## Timing

- Accept at edge E0 with the block idle and empty: the pop occurs at E1, `BUS_D`/`A0` are valid after E1, and `WR` rises after edge E1+`SETUP_CYC`.
- `WR` is high for exactly `STROBE_CYC` cycles, and `BUS_D` is stable for `HOLD_CYC` cycles after it falls.
- `cmd_ready` depends only on storage occupancy, never on `cmd_valid`.
- Simultaneous accept and pop on the same edge is legal. Occupancy is unchanged and no data is lost.
- `busy` is high from the cycle after an accept until the edge that returns the FSM to IDLE with storage empty.

## Configuration

Macro `TBB_WRITER_FIFO_EN`:
- Defined: commands go into a 4-entry FIFO with 2-bit pointers that wrap.
  - `cmd_ready` = not full.
  - When full, an offered command is not accepted and the FIFO state is unchanged.
  - Pop is blocked when empty.
- Undefined: a single holding register is used.
  - `cmd_ready`=1 only when the holding register is empty.
  - The holding register is emptied at the pop edge, so one command can be queued while another is on the bus.

## Test plan

- Single narrow write after reset, defaults, `cmd_a0`=1, `cmd_data`=0x0A, `cmd_wide`=0: `BUS_D`=0xA and `A0`=1 one cycle after the pop, `WR` high for cycles 2–3, one hold cycle, then IDLE with `busy`=0. Total 4 cycles after the pop.
- Wide write, `cmd_data`=0x5C: exactly two `WR` pulses, with `BUS_D`=0xC on the first and 0x5 on the second. `A0` is constant and 8 cycles pass from pop to IDLE.
- Back-to-back narrow commands 0x1, 0x2, 0x3 presented continuously: three `WR` pulses exactly 4 cycles apart, with no IDLE cycle between them.
- With `TBB_WRITER_FIFO_EN`, offer 6 commands while the first is in flight: `cmd_ready` falls when 4 are queued, no command is dropped or duplicated, and the bus order matches the accept order across pointer wrap.
- `RST` pulsed while `WR`=1 mid wide command: `WR`=0 immediately, all outputs at reset values, and no further `WR` pulses after release until a new command is accepted.
- Parameters `SETUP_CYC`=3, `STROBE_CYC`=1, `HOLD_CYC`=15: a single narrow write gives `WR` high 1 cycle, 3 cycles after the pop edge, with `D` held 15 cycles after it falls.
